async_fifo_rd_stream: RTL and testbench
=======================================

# async_fifo_rd_stream

Read-side adapter placed directly downstream of the asynchronous FIFO, in the read clock domain. It drains the FIFO's show-ahead read port (`rd_en`/`rd_data`/`rd_empty`) into a registered valid/ready stream through a 2-entry skid buffer, so the downstream `m_ready` never reaches the FIFO's `rd_en`. It also frames the stream into fixed-length packets with a last-beat marker and a beat index.

## Interface
Parameters:
- `WIDTH`, 8, data width; must match the FIFO `WIDTH`.
- `PKT_LEN`, 16, beats per packet, ≥1.
- `BEAT_W` (localparam), `$clog2(PKT_LEN)` with a minimum of 1, width of `m_beat`.

Ports:
- `rd_clk`  in  1  single clock for the block; the FIFO read clock.
- `rd_arstn`  in  1  reset, asynchronous, active-low.
- `fifo_rd_en`  out  1  pop request to the FIFO `rd_en`.
- `fifo_rd_data`  in  WIDTH  FIFO head data (show-ahead; valid while `fifo_rd_empty`=0).
- `fifo_rd_empty`  in  1  FIFO empty flag.
- `clear`  in  1  synchronous flush of the buffer and packet counter.
- `m_valid`  out  1  output beat valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH  output beat data, registered.
- `m_last`  out  1  high on the final beat of a packet.
- `m_beat`  out  BEAT_W  beat index within the current packet, 0..PKT_LEN-1.

## Operation
- Storage: `head` register (drives `m_data`) and `skid` register. `count` ∈ {0,1,2} gives occupancy. `m_valid` = (`count` != 0).
- `run` flag: resets to 0 and sets to 1 on the first `rd_clk` edge after reset deasserts.
- `fifo_rd_en` = `run` & !`clear` & !`fifo_rd_empty` & (`count` < 2). It depends only on registered state and FIFO flags; there is no combinational path from `m_ready`.
- Events per edge: `push` = `fifo_rd_en`, with `fifo_rd_data` captured at that edge. `pop` = `m_valid` & `m_ready`.
- State transitions (no `clear`):
  - `count`=0: push → head=data, 1.
  - `count`=1: push & pop → head=data, 1. Push only → skid=data, 2. Pop only → 0.
  - `count`=2: pop → head=skid, 1. Push is impossible in this state.
- Order is strict FIFO: the skid entry is always older than any later push.
- Packet counter `m_beat`:
  - Increments on each pop.
  - Wraps to 0 after a pop with `m_beat` = PKT_LEN-1.
  - With PKT_LEN=1 it stays at 0.
- `m_last` = `m_valid` & (`m_beat` == PKT_LEN-1).
- `clear` has priority over all other events:
  - Next state: `count`=0, `m_beat`=0.
  - No FIFO pop occurs in a `clear` cycle.
  - Buffered beats are discarded.
  - A beat presented with `m_ready`=1 in the `clear` cycle is dropped and is not counted.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_data`=0, `m_beat`=0, `fifo_rd_en`=0, `count`=0, `run`=0, skid=0.
- Reset assertion mid-operation immediately forces all outputs to their reset values; buffered data is lost.
- Latency: FIFO non-empty in cycle N (with `count`<2 and `run`=1) → `fifo_rd_en`=1 in cycle N → `m_valid`=1 and `m_data` = that word from cycle N+1.
- Throughput: 1 beat/cycle sustained while the FIFO is non-empty and `m_ready`=1, with `count` steady at 1.
- Stall: `m_ready`=0 fills `count` to 2 after at most 2 pushes, then `fifo_rd_en` drops. After `m_ready` rises, `fifo_rd_en` returns one cycle later, once `count` falls to 1.
- Hold rule: while `m_valid` & !`m_ready`, the values of `m_data`, `m_last` and `m_beat` stay stable.
- FIFO going empty: `fifo_rd_en` falls in the same cycle. Already-buffered beats still drain.

## Test plan
- Reset/startup: hold `rd_arstn`=0 with FIFO non-empty.
  - During reset: `fifo_rd_en`=0, all outputs 0.
  - Release: `fifo_rd_en` stays 0 for one cycle, then rises.
  - The first beat appears 1 cycle after the first pop.
- Streaming: FIFO holds 0x01..0x20, `m_ready`=1, `PKT_LEN`=16.
  - Response: 32 consecutive beats, in order, one per cycle.
  - `m_last`=1 on beats 0x10 and 0x20.
  - `m_beat` wraps 15→0.
- Backpressure: `m_ready`=0 for 5 cycles mid-stream.
  - `count` reaches 2 and `fifo_rd_en`=0.
  - `m_data` is held.
  - After release there is no loss or duplication, and order is 0x05, 0x06, 0x07…
- Empty boundary: FIFO supplies one word 0xA5 then goes empty, with `m_ready`=0 for 3 cycles.
  - A single `m_valid` beat 0xA5 is held for 3 cycles, then accepted.
  - `m_valid` returns to 0 afterward.
- Clear: assert `clear` for 1 cycle with `count`=2 and `m_beat`=7.
  - Next cycle: `m_valid`=0, `m_beat`=0.
  - No FIFO pop in the `clear` cycle.
  - The next beat is the FIFO head word.
- Random: random `m_ready` and random FIFO fill, 10k beats against a scoreboard.
  - Data is an exact sequence match.
  - `m_last` occurs every `PKT_LEN` accepted beats.
  - There is never a cycle with `fifo_rd_en`=1 while `count`=2 or `fifo_rd_empty`=1.

Source files
------------

// File: rtl/async_fifo_rd_stream.sv
// Read-side adapter behind the async FIFO.
// Drains show-ahead FIFO into a framed valid/ready stream.
module async_fifo_rd_stream #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 16,
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic              rd_clk,
  input  logic              rd_arstn,
  output logic              fifo_rd_en,
  input  logic [WIDTH-1:0]  fifo_rd_data,
  input  logic              fifo_rd_empty,
  input  logic              clear,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_last,
  output logic [BEAT_W-1:0] m_beat
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic              run_q;
  logic [1:0]        count_q, count_d;
  logic [WIDTH-1:0]  head_q, head_d;
  logic [WIDTH-1:0]  skid_q, skid_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              push, pop;

  // Pop request uses only registered state and FIFO flags
  always_comb begin
    fifo_rd_en = run_q & ~clear & ~fifo_rd_empty & (count_q != 2'd2);
    push       = fifo_rd_en;
    pop        = (count_q != 2'd0) & m_ready;
  end

  // Occupancy, storage and beat counter registers
  always_ff @(posedge rd_clk or negedge rd_arstn) begin
    if (!rd_arstn) begin
      run_q   <= 1'b0;
      count_q <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
      beat_q  <= '0;
    end else begin
      run_q   <= 1'b1;
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      beat_q  <= beat_d;
    end
  end

  // Next state: clear wins, skid entry is always older than a push
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    beat_d  = beat_q;
    if (clear) begin
      count_d = 2'd0;
      beat_d  = '0;
    end else begin
      if (pop) begin
        beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
      end
      unique case (count_q)
        2'd0: begin
          if (push) begin
            head_d  = fifo_rd_data;
            count_d = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = fifo_rd_data;
          end else if (push) begin
            skid_d  = fifo_rd_data;
            count_d = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d  = skid_q;
            count_d = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  // Stream outputs straight from registers
  always_comb begin
    m_valid = (count_q != 2'd0);
    m_data  = head_q;
    m_beat  = beat_q;
    m_last  = m_valid & (beat_q == LAST_BEAT);
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Directed and random bench for async_fifo_rd_stream.
// FIFO is modelled as a queue with show-ahead head.
module tb_async_fifo_rd_stream;

  localparam int WIDTH   = 8;
  localparam int PKT_LEN = 16;
  localparam int BEAT_W  = 4;

  logic              rd_clk = 1'b0;
  logic              rd_arstn;
  logic              fifo_rd_en;
  logic [WIDTH-1:0]  fifo_rd_data;
  logic              fifo_rd_empty;
  logic              clear;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_data;
  logic              m_last;
  logic [BEAT_W-1:0] m_beat;

  int checks   = 0;
  int failures = 0;
  int occ      = 0;

  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] exq[$];

  async_fifo_rd_stream #(
    .WIDTH(WIDTH),
    .PKT_LEN(PKT_LEN)
  ) dut (
    .rd_clk(rd_clk),
    .rd_arstn(rd_arstn),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .clear(clear),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .m_beat(m_beat)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd();
    fifo_rd_empty = (fq.size() == 0);
    fifo_rd_data  = (fq.size() != 0) ? fq[0] : '0;
    #1;
  endtask

  task automatic set_in(input logic rdy, input logic clr);
    m_ready = rdy;
    clear   = clr;
    upd();
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) fq.push_back(WIDTH'(first + i));
    upd();
  endtask

  task automatic tick();
    bit pu, po;
    pu = fifo_rd_en;
    po = m_valid && m_ready && !clear;
    @(posedge rd_clk);
    if (pu) void'(fq.pop_front());
    if (clear) occ = 0;
    else occ = occ + int'(pu) - int'(po);
    #1;
    upd();
  endtask

  initial begin
    int acc, cyc;
    logic             pv, pr, pl;
    logic [WIDTH-1:0] pd;
    logic [BEAT_W-1:0] pb;

    rd_arstn = 1'b0;
    m_ready  = 1'b0;
    clear    = 1'b0;
    load(1, 32);
    tick();
    tick();
    chk("rst_en", 32'(fifo_rd_en), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_beat", 32'(m_beat), 0);
    chk("rst_last", 32'(m_last), 0);

    rd_arstn = 1'b1;
    set_in(1'b1, 1'b0);
    chk("start_en0", 32'(fifo_rd_en), 0);
    tick();
    chk("start_en1", 32'(fifo_rd_en), 1);
    chk("start_valid0", 32'(m_valid), 0);
    tick();

    for (int i = 1; i <= 32; i++) begin
      chk("stream_valid", 32'(m_valid), 1);
      chk("stream_data", 32'(m_data), 32'(i));
      chk("stream_beat", 32'(m_beat), 32'((i - 1) % 16));
      chk("stream_last", 32'(m_last), 32'(i % 16 == 0));
      tick();
    end
    chk("stream_end_valid", 32'(m_valid), 0);
    chk("stream_end_beat", 32'(m_beat), 0);

    load(1, 12);
    tick();
    for (int v = 1; v <= 4; v++) begin
      chk("bp_pre_data", 32'(m_data), 32'(v));
      tick();
    end
    set_in(1'b0, 1'b0);
    for (int h = 0; h < 5; h++) begin
      chk("bp_hold_data", 32'(m_data), 32'h05);
      chk("bp_hold_valid", 32'(m_valid), 1);
      if (h > 0) begin
        chk("bp_en_low", 32'(fifo_rd_en), 0);
        chk("bp_count2", 32'(dut.count_q), 2);
      end
      tick();
    end
    set_in(1'b1, 1'b0);
    chk("bp_rel_en", 32'(fifo_rd_en), 0);
    chk("bp_rel_data", 32'(m_data), 32'h05);
    tick();
    chk("bp_en_back", 32'(fifo_rd_en), 1);
    for (int v = 6; v <= 12; v++) begin
      chk("bp_post_data", 32'(m_data), 32'(v));
      chk("bp_post_valid", 32'(m_valid), 1);
      tick();
    end
    chk("bp_end_valid", 32'(m_valid), 0);

    set_in(1'b0, 1'b0);
    fq.push_back(8'hA5);
    upd();
    tick();
    for (int h = 0; h < 3; h++) begin
      chk("emp_valid", 32'(m_valid), 1);
      chk("emp_data", 32'(m_data), 32'hA5);
      chk("emp_en", 32'(fifo_rd_en), 0);
      chk("emp_beat", 32'(m_beat), 12);
      tick();
    end
    set_in(1'b1, 1'b0);
    chk("emp_acc_valid", 32'(m_valid), 1);
    tick();
    chk("emp_after_valid", 32'(m_valid), 0);
    chk("emp_after_beat", 32'(m_beat), 13);

    load(8'h31, 12);
    set_in(1'b1, 1'b1);
    chk("clr0_no_pop", 32'(fifo_rd_en), 0);
    tick();
    set_in(1'b1, 1'b0);
    chk("clr0_beat", 32'(m_beat), 0);
    chk("clr0_qsize", 32'(fq.size()), 12);
    tick();
    for (int v = 0; v < 7; v++) begin
      chk("clr_pre_data", 32'(m_data), 32'(8'h31 + v));
      chk("clr_pre_beat", 32'(m_beat), 32'(v));
      tick();
    end
    set_in(1'b0, 1'b0);
    tick();
    chk("clr_count2", 32'(dut.count_q), 2);
    chk("clr_beat7", 32'(m_beat), 7);
    chk("clr_data38", 32'(m_data), 32'h38);
    set_in(1'b1, 1'b1);
    chk("clr_no_pop", 32'(fifo_rd_en), 0);
    tick();
    set_in(1'b1, 1'b0);
    chk("clr_valid", 32'(m_valid), 0);
    chk("clr_beat", 32'(m_beat), 0);
    chk("clr_qsize", 32'(fq.size()), 3);
    chk("clr_en", 32'(fifo_rd_en), 1);
    tick();
    for (int v = 0; v < 3; v++) begin
      chk("clr_post_data", 32'(m_data), 32'(8'h3A + v));
      chk("clr_post_beat", 32'(m_beat), 32'(v));
      tick();
    end
    chk("clr_end_valid", 32'(m_valid), 0);

    set_in(1'b0, 1'b1);
    tick();
    set_in(1'b0, 1'b0);
    acc = 0;
    cyc = 0;
    pv  = 1'b0;
    pr  = 1'b0;
    pd  = '0;
    pl  = 1'b0;
    pb  = '0;
    while (acc < 10000 && cyc < 60000) begin
      if (fq.size() < 16 && $urandom_range(0, 3) != 0) begin
        logic [WIDTH-1:0] w;
        w = WIDTH'($urandom);
        fq.push_back(w);
        exq.push_back(w);
      end
      set_in($urandom_range(0, 9) < 7, 1'b0);
      if (pv && !pr) begin
        chk("rnd_hold_data", 32'(m_data), 32'(pd));
        chk("rnd_hold_last", 32'(m_last), 32'(pl));
        chk("rnd_hold_beat", 32'(m_beat), 32'(pb));
      end
      chk("rnd_valid", 32'(m_valid), 32'(occ != 0));
      if (fifo_rd_en) begin
        chk("rnd_en_full", 32'(occ < 2), 1);
        chk("rnd_en_empty", 32'(fifo_rd_empty), 0);
      end
      if (m_valid && m_ready) begin
        chk("rnd_data", 32'(m_data),
            32'((exq.size() != 0) ? exq.pop_front() : 8'hxx));
        chk("rnd_last", 32'(m_last),
            32'(acc % PKT_LEN == PKT_LEN - 1));
        acc++;
      end
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      pl = m_last;
      pb = m_beat;
      tick();
      cyc++;
    end
    chk("rnd_beats_done", 32'(acc), 10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
